uart_tx_arbiter: RTL and testbench

//  Shares the single UART TX packet stream between N packet sources (read controller,

---
 rtl/uart_tx_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
// Packet-atomic round-robin arbiter merging N packet sources onto one UART TX stream.
// Latency: 1 cycle to arbitrate from IDLE, then zero-latency combinational pass-through of the granted source.
// Backpressure: ipTxReady feeds straight back to the granted source's ready; non-granted sources are held.
//
// Ports:
//   ipClk, ipReset               clock, asynchronous active-low reset
//   ipSrcValid/SoP/EoP [N]       per-source beat handshake and framing flags
//   ipSrcDest/Source/Length/Data per-source 8-bit fields, source i at [8i+7:8i]
//   opSrcReady [N]               per-source ready (grant in PASS, orphan discard in IDLE)
//   opTxStream / ipTxReady       merged packet stream to the UART packetiser and its ready
//   opGrant [N]                  registered one-hot grant, 0 when idle
//   opTimeout                    one-cycle pulse when the watchdog revokes a grant
//   opDropCount [8]              saturating count of cycles that discarded orphan beats

package uart_tx_arbiter_pkg;
  typedef struct packed {
    logic       Valid;
    logic       SoP;
    logic       EoP;
    logic [7:0] Dest;
    logic [7:0] Source;
    logic [7:0] Length;
    logic [7:0] Data;
  } UART_PACKET;
endpackage

module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N       = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic             ipClk,
  input  logic             ipReset,
  input  logic [N-1:0]     ipSrcValid,
  input  logic [N-1:0]     ipSrcSoP,
  input  logic [N-1:0]     ipSrcEoP,
  input  logic [8*N-1:0]   ipSrcDest,
  input  logic [8*N-1:0]   ipSrcSource,
  input  logic [8*N-1:0]   ipSrcLength,
  input  logic [8*N-1:0]   ipSrcData,
  output logic [N-1:0]     opSrcReady,
  output UART_PACKET       opTxStream,
  input  logic             ipTxReady,
  output logic [N-1:0]     opGrant,
  output logic             opTimeout,
  output logic [7:0]       opDropCount
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = IW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, PASS} state_t;

  state_t        state, stateNext;
  logic [IW-1:0] grantIdx, grantIdxNext;
  logic [IW-1:0] rrPtr, rrPtrNext;
  logic [N-1:0]  grantNext;
  logic [WW-1:0] wdCnt, wdCntNext;
  logic          timeoutNext;
  logic [7:0]    dropNext;

  logic          found;
  logic [IW-1:0] winIdx;
  logic [SW-1:0] scanSum;
  logic [IW-1:0] scanIdx;
  logic [N-1:0]  orphanVec;
  logic          beatAcc;
  logic          wdTick;
  logic [IW-1:0] nextPtr;

  assign orphanVec = ipSrcValid & ~ipSrcSoP;
  assign beatAcc   = ipSrcValid[grantIdx] & ipTxReady;
  // Only a silent source counts toward the watchdog; a stalled sink never does.
  assign wdTick    = ~ipSrcValid[grantIdx] & ipTxReady;
  assign nextPtr   = (grantIdx == IW'(N - 1)) ? '0 : grantIdx + 1'b1;

  // Round-robin scan: first source with Valid & SoP at or after rrPtr, wrapping mod N.
  always_comb begin
    found   = 1'b0;
    winIdx  = '0;
    scanSum = '0;
    scanIdx = '0;
    for (int k = 0; k < N; k++) begin
      scanSum = {1'b0, rrPtr} + SW'(k);
      if (scanSum >= SW'(N)) begin
        scanSum = scanSum - SW'(N);
      end
      scanIdx = scanSum[IW-1:0];
      if (!found && ipSrcValid[scanIdx] && ipSrcSoP[scanIdx]) begin
        found  = 1'b1;
        winIdx = scanIdx;
      end
    end
  end

  // Datapath: zero-latency mux in PASS; in IDLE only orphan beats are acknowledged.
  // Ready is gated by ipReset so a source cannot see an acknowledge while reset is held.
  always_comb begin
    opTxStream = '0;
    opSrcReady = '0;
    if (ipReset) begin
      if (state == PASS) begin
        opTxStream.Valid  = ipSrcValid[grantIdx];
        opTxStream.SoP    = ipSrcSoP[grantIdx];
        opTxStream.EoP    = ipSrcEoP[grantIdx];
        opTxStream.Dest   = ipSrcDest[{grantIdx, 3'b000} +: 8];
        opTxStream.Source = ipSrcSource[{grantIdx, 3'b000} +: 8];
        opTxStream.Length = ipSrcLength[{grantIdx, 3'b000} +: 8];
        opTxStream.Data   = ipSrcData[{grantIdx, 3'b000} +: 8];
        opSrcReady[grantIdx] = ipTxReady;
      end else begin
        opSrcReady = orphanVec;
      end
    end
  end

  always_comb begin
    stateNext    = state;
    grantIdxNext = grantIdx;
    grantNext    = opGrant;
    rrPtrNext    = rrPtr;
    wdCntNext    = wdCnt;
    timeoutNext  = 1'b0;
    dropNext     = opDropCount;
    case (state)
      IDLE: begin
        if (|orphanVec && (opDropCount != 8'hFF)) begin
          dropNext = opDropCount + 8'd1;
        end
        if (found) begin
          stateNext         = PASS;
          grantIdxNext      = winIdx;
          grantNext         = '0;
          grantNext[winIdx] = 1'b1;
          wdCntNext         = '0;
        end
      end
      PASS: begin
        if (beatAcc) begin
          wdCntNext = '0;
          if (ipSrcEoP[grantIdx]) begin
            stateNext = IDLE;
            grantNext = '0;
            rrPtrNext = nextPtr;
          end
        end else if (wdTick) begin
          if (wdCnt == WW'(TIMEOUT - 1)) begin
            stateNext   = IDLE;
            grantNext   = '0;
            rrPtrNext   = nextPtr;
            wdCntNext   = '0;
            timeoutNext = 1'b1;
          end else begin
            wdCntNext = wdCnt + 1'b1;
          end
        end
      end
      default: begin
        stateNext = IDLE;
        grantNext = '0;
      end
    endcase
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state       <= IDLE;
      grantIdx    <= '0;
      opGrant     <= '0;
      rrPtr       <= '0;
      wdCnt       <= '0;
      opTimeout   <= 1'b0;
      opDropCount <= 8'd0;
    end else begin
      state       <= stateNext;
      grantIdx    <= grantIdxNext;
      opGrant     <= grantNext;
      rrPtr       <= rrPtrNext;
      wdCnt       <= wdCntNext;
      opTimeout   <= timeoutNext;
      opDropCount <= dropNext;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
// Bench for uart_tx_arbiter: cycle vectors plus hand sequences, TX beats checked by a queue scoreboard.
// Latency: inputs driven 1ns after the rising edge, outputs sampled 4ns after it, TX beats at the falling edge.
// Backpressure: ipTxReady driven directly from the vectors and sequences.
module tb_uart_tx_arbiter;
  import uart_tx_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int TO = 16;

  logic           ipClk = 1'b0;
  logic           ipReset;
  logic [N-1:0]   ipSrcValid, ipSrcSoP, ipSrcEoP;
  logic [8*N-1:0] ipSrcDest, ipSrcSource, ipSrcLength, ipSrcData;
  logic [N-1:0]   opSrcReady;
  UART_PACKET     opTxStream;
  logic           ipTxReady;
  logic [N-1:0]   opGrant;
  logic           opTimeout;
  logic [7:0]     opDropCount;

  uart_tx_arbiter #(.N(N), .TIMEOUT(TO)) dut (
    .ipClk(ipClk), .ipReset(ipReset),
    .ipSrcValid(ipSrcValid), .ipSrcSoP(ipSrcSoP), .ipSrcEoP(ipSrcEoP),
    .ipSrcDest(ipSrcDest), .ipSrcSource(ipSrcSource),
    .ipSrcLength(ipSrcLength), .ipSrcData(ipSrcData),
    .opSrcReady(opSrcReady), .opTxStream(opTxStream), .ipTxReady(ipTxReady),
    .opGrant(opGrant), .opTimeout(opTimeout), .opDropCount(opDropCount)
  );

  always #5 ipClk = ~ipClk;

  int checks   = 0;
  int failures = 0;
  UART_PACKET sbQ[$];
  UART_PACKET monExp;

  typedef struct {
    logic [2:0]  v, s, e;
    logic [23:0] d;
    logic        tr;
    logic [2:0]  gnt, rdy;
    logic        vld;
    logic [7:0]  drop;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic UART_PACKET mkBeat(input int i, input logic sop, input logic eop,
                                        input logic [7:0] data);
    UART_PACKET p;
    p.Valid  = 1'b1;
    p.SoP    = sop;
    p.EoP    = eop;
    p.Dest   = 8'hD0 + 8'(i);
    p.Source = 8'h50 + 8'(i);
    p.Length = 8'h30 + 8'(i);
    p.Data   = data;
    return p;
  endfunction

  function automatic vec_t V(input logic [2:0] v, input logic [2:0] s, input logic [2:0] e,
                             input logic [23:0] d, input logic tr, input logic [2:0] gnt,
                             input logic [2:0] rdy, input logic vld, input logic [7:0] drop);
    vec_t r;
    r.v = v; r.s = s; r.e = e; r.d = d; r.tr = tr;
    r.gnt = gnt; r.rdy = rdy; r.vld = vld; r.drop = drop;
    return r;
  endfunction

  task automatic drive(input logic [2:0] v, input logic [2:0] s, input logic [2:0] e,
                       input logic [23:0] d, input logic tr);
    ipSrcValid = v;
    ipSrcSoP   = s;
    ipSrcEoP   = e;
    ipSrcData  = d;
    ipTxReady  = tr;
  endtask

  task automatic cyc();
    @(posedge ipClk);
    #1;
  endtask

  // Scoreboard: every beat the merged stream hands over must be the next expected one.
  always @(negedge ipClk) begin
    if (ipReset && opTxStream.Valid && ipTxReady) begin
      if (sbQ.size() == 0) begin
        chk("unexpected_tx_beat", 64'(opTxStream), 64'(0));
      end else begin
        monExp = sbQ.pop_front();
        chk("tx_beat", 64'(opTxStream), 64'(monExp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000ns");
    $fatal(1);
  end

  initial begin
    vec_t r;
    int   bad;

    //     v       s       e       data          tr    gnt     rdy     vld   drop
    // Three-beat packet from src1.
    vt.push_back(V(3'b010, 3'b010, 3'b000, 24'h001100, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0));
    vt.push_back(V(3'b010, 3'b010, 3'b000, 24'h001100, 1'b1, 3'b010, 3'b010, 1'b1, 8'd0));
    vt.push_back(V(3'b010, 3'b000, 3'b000, 24'h002200, 1'b1, 3'b010, 3'b010, 1'b1, 8'd0));
    vt.push_back(V(3'b010, 3'b000, 3'b010, 24'h003300, 1'b1, 3'b010, 3'b010, 1'b1, 8'd0));
    vt.push_back(V(3'b000, 3'b000, 3'b000, 24'h000000, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0));
    // Single-beat packet from src2 brings the pointer back to 0.
    vt.push_back(V(3'b100, 3'b100, 3'b100, 24'h440000, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0));
    vt.push_back(V(3'b100, 3'b100, 3'b100, 24'h440000, 1'b1, 3'b100, 3'b100, 1'b1, 8'd0));
    vt.push_back(V(3'b000, 3'b000, 3'b000, 24'h000000, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0));
    // src0 and src2 contend with pointer 0: src0 first, src2 after one idle cycle.
    vt.push_back(V(3'b101, 3'b101, 3'b000, 24'hC000A0, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0));
    vt.push_back(V(3'b101, 3'b101, 3'b000, 24'hC000A0, 1'b1, 3'b001, 3'b001, 1'b1, 8'd0));
    vt.push_back(V(3'b101, 3'b100, 3'b001, 24'hC000A1, 1'b1, 3'b001, 3'b001, 1'b1, 8'd0));
    // src0 re-requests; pointer is now 1 so src2 wins over the lower index.
    vt.push_back(V(3'b101, 3'b101, 3'b001, 24'hC000B0, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0));
    vt.push_back(V(3'b101, 3'b101, 3'b001, 24'hC000B0, 1'b1, 3'b100, 3'b100, 1'b1, 8'd0));
    vt.push_back(V(3'b101, 3'b001, 3'b101, 24'hC100B0, 1'b1, 3'b100, 3'b100, 1'b1, 8'd0));
    vt.push_back(V(3'b001, 3'b001, 3'b001, 24'h0000B0, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0));
    vt.push_back(V(3'b001, 3'b001, 3'b001, 24'h0000B0, 1'b1, 3'b001, 3'b001, 1'b1, 8'd0));
    vt.push_back(V(3'b000, 3'b000, 3'b000, 24'h000000, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0));
    // Four-beat src1 packet with TX ready low for five cycles mid-packet.
    vt.push_back(V(3'b010, 3'b010, 3'b000, 24'h00D000, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0));
    vt.push_back(V(3'b010, 3'b010, 3'b000, 24'h00D000, 1'b1, 3'b010, 3'b010, 1'b1, 8'd0));
    for (int i = 0; i < 5; i++)
      vt.push_back(V(3'b010, 3'b000, 3'b000, 24'h00D100, 1'b0, 3'b010, 3'b000, 1'b1, 8'd0));
    vt.push_back(V(3'b010, 3'b000, 3'b000, 24'h00D100, 1'b1, 3'b010, 3'b010, 1'b1, 8'd0));
    vt.push_back(V(3'b010, 3'b000, 3'b000, 24'h00D200, 1'b1, 3'b010, 3'b010, 1'b1, 8'd0));
    vt.push_back(V(3'b010, 3'b000, 3'b010, 24'h00D300, 1'b1, 3'b010, 3'b010, 1'b1, 8'd0));
    vt.push_back(V(3'b000, 3'b000, 3'b000, 24'h000000, 1'b1, 3'b000, 3'b000, 1'b0, 8'd0));
    // Orphan beats from src0 in IDLE are acknowledged and counted.
    vt.push_back(V(3'b001, 3'b000, 3'b000, 24'h0000E0, 1'b1, 3'b000, 3'b001, 1'b0, 8'd0));
    vt.push_back(V(3'b001, 3'b000, 3'b000, 24'h0000E1, 1'b1, 3'b000, 3'b001, 1'b0, 8'd1));
    vt.push_back(V(3'b001, 3'b000, 3'b000, 24'h0000E2, 1'b1, 3'b000, 3'b001, 1'b0, 8'd2));
    vt.push_back(V(3'b000, 3'b000, 3'b000, 24'h000000, 1'b1, 3'b000, 3'b000, 1'b0, 8'd3));

    ipSrcDest   = {8'hD2, 8'hD1, 8'hD0};
    ipSrcSource = {8'h52, 8'h51, 8'h50};
    ipSrcLength = {8'h32, 8'h31, 8'h30};
    ipReset     = 1'b0;
    drive(3'b000, 3'b000, 3'b000, 24'h0, 1'b1);
    #12;
    // An orphan presented during reset must not be acknowledged.
    drive(3'b001, 3'b000, 3'b000, 24'h0000EE, 1'b1);
    #1;
    chk("rst_grant", 64'(opGrant), 64'(0));
    chk("rst_ready", 64'(opSrcReady), 64'(0));
    chk("rst_tx", 64'(opTxStream), 64'(0));
    chk("rst_timeout", 64'(opTimeout), 64'(0));
    chk("rst_drop", 64'(opDropCount), 64'(0));
    drive(3'b000, 3'b000, 3'b000, 24'h0, 1'b1);
    @(posedge ipClk);
    #2;
    ipReset = 1'b1;

    foreach (vt[k]) begin
      r = vt[k];
      cyc();
      drive(r.v, r.s, r.e, r.d, r.tr);
      if (r.vld && r.tr) begin
        for (int i = 0; i < N; i++)
          if (r.gnt[i]) sbQ.push_back(mkBeat(i, r.s[i], r.e[i], r.d[8*i +: 8]));
      end
      #3;
      chk($sformatf("r%0d_grant", k), 64'(opGrant), 64'(r.gnt));
      chk($sformatf("r%0d_ready", k), 64'(opSrcReady), 64'(r.rdy));
      chk($sformatf("r%0d_txvalid", k), 64'(opTxStream.Valid), 64'(r.vld));
      chk($sformatf("r%0d_timeout", k), 64'(opTimeout), 64'(0));
      chk($sformatf("r%0d_drop", k), 64'(opDropCount), 64'(r.drop));
    end

    // Asynchronous reset on beat 3 of a 4-beat src0 packet.
    cyc(); drive(3'b001, 3'b001, 3'b000, 24'h0000F0, 1'b1); #3;
    chk("t6_idle_grant", 64'(opGrant), 64'(0));
    cyc(); sbQ.push_back(mkBeat(0, 1'b1, 1'b0, 8'hF0)); #3;
    chk("t6_grant", 64'(opGrant), 64'(3'b001));
    cyc(); drive(3'b001, 3'b000, 3'b000, 24'h0000F1, 1'b1); sbQ.push_back(mkBeat(0, 1'b0, 1'b0, 8'hF1));
    cyc(); drive(3'b001, 3'b000, 3'b000, 24'h0000F2, 1'b1);
    #1; ipReset = 1'b0;
    #1;
    chk("t6_rst_grant", 64'(opGrant), 64'(0));
    chk("t6_rst_ready", 64'(opSrcReady), 64'(0));
    chk("t6_rst_tx", 64'(opTxStream), 64'(0));
    chk("t6_rst_drop", 64'(opDropCount), 64'(0));
    cyc(); drive(3'b000, 3'b000, 3'b000, 24'h0, 1'b1); #1; ipReset = 1'b1;
    cyc(); drive(3'b001, 3'b001, 3'b001, 24'h00005A, 1'b1); #3;
    chk("t6_post_idle", 64'(opGrant), 64'(0));
    cyc(); sbQ.push_back(mkBeat(0, 1'b1, 1'b1, 8'h5A)); #3;
    chk("t6_post_grant", 64'(opGrant), 64'(3'b001));
    cyc(); drive(3'b000, 3'b000, 3'b000, 24'h0, 1'b1); #3;
    chk("t6_post_release", 64'(opGrant), 64'(0));

    // Watchdog: src1 goes silent after SoP while src2 waits.
    cyc(); drive(3'b110, 3'b110, 3'b100, 24'h887700, 1'b1); #3;
    chk("t4_idle_grant", 64'(opGrant), 64'(0));
    cyc(); sbQ.push_back(mkBeat(1, 1'b1, 1'b0, 8'h77)); #3;
    chk("t4_grant", 64'(opGrant), 64'(3'b010));
    bad = 0;
    for (int c = 0; c < TO; c++) begin
      cyc(); drive(3'b100, 3'b100, 3'b100, 24'h880000, 1'b1); #3;
      if (opTimeout !== 1'b0 || opGrant !== 3'b010) bad++;
    end
    chk("t4_hold_before_timeout", 64'(bad), 64'(0));
    cyc(); #3;
    chk("t4_timeout_pulse", 64'(opTimeout), 64'(1));
    chk("t4_timeout_grant", 64'(opGrant), 64'(0));
    chk("t4_timeout_txvalid", 64'(opTxStream.Valid), 64'(0));
    cyc(); sbQ.push_back(mkBeat(2, 1'b1, 1'b1, 8'h88)); #3;
    chk("t4_pulse_end", 64'(opTimeout), 64'(0));
    chk("t4_next_grant", 64'(opGrant), 64'(3'b100));
    cyc(); drive(3'b000, 3'b000, 3'b000, 24'h0, 1'b1); #3;
    chk("t4_release", 64'(opGrant), 64'(0));

    // Downstream backpressure longer than TIMEOUT must not trip the watchdog.
    cyc(); drive(3'b001, 3'b001, 3'b000, 24'h000099, 1'b1);
    cyc(); sbQ.push_back(mkBeat(0, 1'b1, 1'b0, 8'h99)); #3;
    chk("bp_grant", 64'(opGrant), 64'(3'b001));
    bad = 0;
    for (int c = 0; c < TO + 4; c++) begin
      cyc(); drive(3'b000, 3'b000, 3'b000, 24'h0, 1'b0); #3;
      if (opTimeout !== 1'b0 || opGrant !== 3'b001) bad++;
    end
    chk("bp_no_timeout", 64'(bad), 64'(0));
    cyc(); drive(3'b001, 3'b000, 3'b001, 24'h00009A, 1'b1); sbQ.push_back(mkBeat(0, 1'b0, 1'b1, 8'h9A)); #3;
    chk("bp_eop_grant", 64'(opGrant), 64'(3'b001));
    cyc(); drive(3'b000, 3'b000, 3'b000, 24'h0, 1'b1); #3;
    chk("bp_release", 64'(opGrant), 64'(0));
    chk("bp_timeout_low", 64'(opTimeout), 64'(0));

    chk("scoreboard_drained", 64'(sbQ.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
